mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Scan controller that sits directly upstream of the 8:1 single-bit mux. It drives the mux select through channels 0..7 and samples the mux output after a programmable settle time. It assembles the eight samples into a byte and reports completion with a one-cycle pulse. It converts eight static channel inputs into one registered parallel word without requiring eight capture flops at the source.

## Interface
Parameters:
- SETTLE, default 1: idle cycles between a `sel` change and the sample of `y_in`. Legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high. Clears all state immediately, independent of `clk`.
- start  input  1  request one scan. Sampled only in IDLE; ignored while `busy`.
- cont  input  1  continuous mode. Sampled at scan completion; if high, the next scan begins with no gap.
- sel  output  3  mux select, registered.
- y_in  input  1  mux output, fed back from the downstream mux.
- data_out  output  8  last completed scan; bit k = value sampled with `sel`=k.
- done  output  1  one-cycle pulse; `data_out` is valid and new in the same cycle.
- busy  output  1  high while a scan is in progress.

## Operation
- **States:**
  - IDLE: `busy`=0, `sel`=0.
  - SCAN: `busy`=1.
- **Reset values:** `sel`=0, `data_out`=0, `done`=0, `busy`=0; state IDLE; internal shift register, index and wait counter cleared.
- **IDLE → SCAN:** at the edge where `start`=1. The edge sets index=0, `sel`=0, wcnt=SETTLE.
- **SCAN, wcnt≠0:** decrement wcnt. `sel` holds.
- **SCAN, wcnt=0:** capture `y_in` into internal bit[index].
  - If index<7: index+1, `sel`=index+1, wcnt=SETTLE.
  - If index=7: on the same edge, copy the assembled byte (including the bit just captured) to `data_out` and set `done`=1 for one cycle.
    - `cont`=1: stay in SCAN, index=0, `sel`=0, wcnt=SETTLE, `busy` stays 1.
    - `cont`=0: go to IDLE, `sel`=0, `busy`=0.
- **`data_out` hold:** changes only at completion. It is never partially updated.
- **`start` during SCAN:** ignored and not queued.
- **`start` and `cont` together in IDLE:** `start` begins the scan. `cont` is only relevant at completion.
- **Reset mid-scan:** partial byte discarded, `data_out` cleared, no `done` pulse.
- **Return from continuous mode:** after `cont` drops, the current scan finishes normally and then returns to IDLE.

## Timing
- Let E0 be the edge that accepts `start`.
- Bit k is sampled at edge E0 + (k+1)(SETTLE+1).
- `done` and the new `data_out` are visible in the cycle after edge E0 + 8(SETTLE+1). Examples:
  - SETTLE=1: 16 cycles.
  - SETTLE=0: 8 cycles, one bit per clock.
- `sel` changes on the same edge that samples the previous bit. The mux therefore has SETTLE+1 full cycles of stable select before each sample.
- In continuous mode, `done` pulses every 8(SETTLE+1) cycles with no dead cycles.
- `busy` rises the cycle after `start` is accepted. It falls the same cycle `done` is high, in non-continuous mode.
- Earliest new `start` after `done`: the `done` cycle itself (state is already IDLE).

## Structure
- **Package `mux_scan_pkg`:**
  - state enum {IDLE, SCAN}
  - NUM_CH = 8
  - SEL_W = 3
  - SETTLE_MAX = 15
  - width of wcnt = 4
- **Natural sub-module `scan_settle_cnt`:** loadable down-counter.
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Reused for any future channel-scan blocks.
- **Top level:** FSM, index counter, 8-bit assembly register, output registers.

## Test plan
- **Basic scan:** SETTLE=1; channel inputs on the downstream mux = 8'b1010_0110; pulse `start` for 1 cycle → `sel` steps 0..7, each held 2 cycles; `done` high exactly 16 cycles after acceptance; `data_out`=8'hA6; `busy` 1→0 with `done`.
- **Zero settle:** SETTLE=0, channels = 8'hFF → `sel` changes every cycle; `done` at cycle 8; `data_out`=8'hFF.
- **Ignored start:** re-assert `start` at cycle 5 of a SETTLE=1 scan → no restart; single `done` at cycle 16; `sel` sequence unaffected.
- **Continuous mode:** SETTLE=1, `cont`=1, change channels from 8'h3C to 8'hC3 after the first `done` → `done` pulses at cycles 16 and 32; `data_out` 8'h3C then 8'hC3. Drop `cont` before the second completion → `busy`=0 after the second `done`.
- **Async reset mid-scan:** assert `rst` between clock edges at cycle 9 → `sel`, `busy`, `done`, `data_out` go to 0 immediately; no `done` afterwards. Next `start` produces a full, correct scan.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and types for the channel-scan controller slice.
package mux_scan_pkg;

    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned WCNT_W     = 4;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan handshake and mux feedback signals between the controller and its user.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              cont;
    logic [SEL_W-1:0]  sel;
    logic              y_in;
    logic [NUM_CH-1:0] data_out;
    logic              done;
    logic              busy;

    modport master (
        output start, cont, y_in,
        input  sel, data_out, done, busy
    );

    modport slave (
        input  start, cont, y_in,
        output sel, data_out, done, busy
    );

endinterface

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// Loadable down-counter that stops at zero; used to time mux settling.
module scan_settle_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux select through all channels and assembles the sampled bits into a byte.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);

    localparam logic [WCNT_W-1:0] SETTLE_LD = WCNT_W'(SETTLE);
    localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NUM_CH - 1);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  idx;
    logic [NUM_CH-1:0] shreg, shreg_nxt;
    logic              cnt_load;
    logic              cnt_zero;
    logic              capture;
    logic              last;

    scan_settle_cnt #(.W(WCNT_W)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LD),
        .en       (state == SCAN),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        capture   = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SCAN;
                    cnt_load  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                    last    = (idx == LAST_IDX);
                    if (!last || bus.cont) begin
                        cnt_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte including the bit captured this edge, so data_out gets all eight at once
    always_comb begin
        shreg_nxt      = shreg;
        shreg_nxt[idx] = bus.y_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            shreg        <= '0;
            bus.sel      <= '0;
            bus.data_out <= '0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if ((state == IDLE) && bus.start) begin
                idx     <= '0;
                bus.sel <= '0;
            end
            if (capture) begin
                shreg <= shreg_nxt;
                if (last) begin
                    bus.data_out <= shreg_nxt;
                    bus.done     <= 1'b1;
                    idx          <= '0;
                    bus.sel      <= '0;
                end else begin
                    idx     <= idx + 1'b1;
                    bus.sel <= idx + 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state == SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: stimulus pushes expected bytes and completion cycles, monitors pop on done.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_scan_ctrl_if if1 ();
    mux_scan_ctrl_if if0 ();

    logic [7:0] ch1 = 8'h00;
    logic [7:0] ch0 = 8'h00;

    // Downstream 8:1 mux models
    assign if1.y_in = ch1[if1.sel];
    assign if0.y_in = ch0[if0.sel];

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    mux_scan_ctrl #(.SETTLE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   e0_1    = 0;
    int   e0_0    = 0;
    bit   trk1    = 1'b0;
    bit   trk0    = 1'b0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t m1;
    exp_t m0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (trk1) chk("sel1", 32'(if1.sel), 32'(((cyc - e0_1) / 2) % 8));
            if (if1.done) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", 32'd1, 32'd0);
                end else begin
                    m1 = q1.pop_front();
                    chk("data1", 32'(if1.data_out), 32'(m1.d));
                    chk("done1_cycle", 32'(cyc), 32'(m1.c));
                end
                if (!if1.busy) trk1 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (trk0) chk("sel0", 32'(if0.sel), 32'((cyc - e0_0) % 8));
            if (if0.done) begin
                if (q0.size() == 0) begin
                    chk("done0_unexpected", 32'd1, 32'd0);
                end else begin
                    m0 = q0.pop_front();
                    chk("data0", 32'(if0.data_out), 32'(m0.d));
                    chk("done0_cycle", 32'(cyc), 32'(m0.c));
                end
                if (!if0.busy) trk0 = 1'b0;
            end
        end
    end

    task automatic go1(input logic [7:0] d, input logic c);
        @(negedge clk);
        ch1       = d;
        if1.cont  = c;
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        e0_1      = cyc;
        trk1      = 1'b1;
        q1.push_back('{d, cyc + 16});
        chk("busy1_rise", 32'(if1.busy), 32'd1);
    endtask

    task automatic go0(input logic [7:0] d);
        @(negedge clk);
        ch0       = d;
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        e0_0      = cyc;
        trk0      = 1'b1;
        q0.push_back('{d, cyc + 8});
        chk("busy0_rise", 32'(if0.busy), 32'd1);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle1();
        int n = 0;
        while (if1.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle1_timeout", 32'(if1.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        if1.start = 1'b0;
        if1.cont  = 1'b0;
        if0.start = 1'b0;
        if0.cont  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sel",   32'(if1.sel), 32'd0);
        chk("rst_data",  32'(if1.data_out), 32'd0);
        chk("rst_done",  32'(if1.done), 32'd0);
        chk("rst_busy",  32'(if1.busy), 32'd0);
        chk("rst_busy0", 32'(if0.busy), 32'd0);
        rst = 1'b0;

        go1(8'hA6, 1'b0);
        wait_until(e0_1 + 16);
        chk("basic_busy_fall", 32'(if1.busy), 32'd0);
        chk("basic_done", 32'(if1.done), 32'd1);
        wait_idle1();

        go0(8'hFF);
        wait_until(e0_0 + 8);
        chk("zero_busy_fall", 32'(if0.busy), 32'd0);
        chk("zero_done", 32'(if0.done), 32'd1);

        go1(8'h5C, 1'b0);
        wait_until(e0_1 + 5);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        chk("ign_busy", 32'(if1.busy), 32'd1);
        wait_until(e0_1 + 16);
        chk("ign_done", 32'(if1.done), 32'd1);
        wait_idle1();
        repeat (20) @(negedge clk);

        go1(8'h3C, 1'b1);
        q1.push_back('{8'hC3, e0_1 + 32});
        wait_until(e0_1 + 16);
        chk("cont_busy_mid", 32'(if1.busy), 32'd1);
        ch1      = 8'hC3;
        if1.cont = 1'b0;
        wait_until(e0_1 + 32);
        chk("cont_done2", 32'(if1.done), 32'd1);
        chk("cont_busy_fall", 32'(if1.busy), 32'd0);
        wait_idle1();

        go1(8'h5A, 1'b0);
        wait_until(e0_1 + 9);
        trk1 = 1'b0;
        q1.delete();
        rst = 1'b1;
        #1;
        chk("arst_sel",  32'(if1.sel), 32'd0);
        chk("arst_busy", 32'(if1.busy), 32'd0);
        chk("arst_done", 32'(if1.done), 32'd0);
        chk("arst_data", 32'(if1.data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        go1(8'h81, 1'b0);
        wait_idle1();
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(q1.size() + q0.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
